// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundles the ROM port, the decode-side valid/ready output stage, the
// redirect request and the halt status of the instruction fetch unit.
//
// Modports:
//   master - the fetch unit: drives rom_addr, out_valid, out_instr, out_pc, halted;
//            samples rom_data, out_ready, redirect_valid, redirect_pc.
//   slave  - the environment (ROM + decode + branch logic): the mirror image.
interface instr_fetch_if #(
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned INSTR_W = 8
) ();

   logic [ADDR_W-1:0]  rom_addr;
   logic [INSTR_W-1:0] rom_data;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [ADDR_W-1:0]  out_pc;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               halted;

   modport master (
      output rom_addr,
      input  rom_data,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc,
      input  redirect_valid,
      input  redirect_pc,
      output halted
   );

   modport slave (
      input  rom_addr,
      output rom_data,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc,
      output redirect_valid,
      output redirect_pc,
      input  halted
   );

endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit for the 4-bit processor. Owns the PC, addresses a
// zero-latency instruction ROM and registers each word into a single-entry valid/ready
// output stage toward decode. Supports PC redirects and stops after fetching a halt
// instruction (opcode bits [7:6] == 2'b11).
//
// Ports:
//   clk            - system clock, rising edge
//   rst_n          - asynchronous active-low reset
//   bus (master)   - rom_addr/rom_data, out_valid/out_ready/out_instr/out_pc,
//                    redirect_valid/redirect_pc, halted (see instr_fetch_if)
//   perf_fetch_cnt - saturating count of fetches            (FETCH_PERF_CNT_EN only)
//   perf_stall_cnt - saturating count of RUN backpressure cycles (FETCH_PERF_CNT_EN only)
//
// Optional feature macro: FETCH_PERF_CNT_EN adds the two performance counters.
module instr_fetch #(
   parameter int unsigned     ADDR_W   = 4,
   parameter int unsigned     INSTR_W  = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic           clk,
   input logic           rst_n,
   instr_fetch_if.master bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [7:0]    perf_fetch_cnt,
   output logic [7:0]    perf_stall_cnt
`endif
);

   localparam logic [0:0] StRun  = 1'b0;
   localparam logic [0:0] StHalt = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic               out_valid_q, out_valid_d;
   logic [INSTR_W-1:0] out_instr_q, out_instr_d;
   logic [ADDR_W-1:0]  out_pc_q, out_pc_d;

   logic stage_free;
   logic fetch;
   logic is_halt_op;

   assign stage_free = !out_valid_q || bus.out_ready;
   // A redirect pre-empts the fetch in the same cycle.
   assign fetch      = (state_q == StRun) && stage_free && !bus.redirect_valid;
   assign is_halt_op = (bus.rom_data[INSTR_W-1 -: 2] == 2'b11);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
      if (bus.redirect_valid) begin
         // Discard any held instruction, even under backpressure.
         out_valid_d = 1'b0;
         pc_d        = bus.redirect_pc;
         state_d     = StRun;
      end else if (fetch) begin
         out_valid_d = 1'b1;
         out_instr_d = bus.rom_data;
         out_pc_d    = pc_q;
         if (is_halt_op) begin
            state_d = StHalt;
         end else begin
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
         end
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StRun;
         pc_q        <= RESET_PC;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
      end
   end

   assign bus.rom_addr  = pc_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_instr = out_instr_q;
   assign bus.out_pc    = out_pc_q;
   assign bus.halted    = (state_q == StHalt);

`ifdef FETCH_PERF_CNT_EN
   logic [7:0] fetch_cnt_q;
   logic [7:0] stall_cnt_q;
   logic       stall;

   assign stall = (state_q == StRun) && out_valid_q && !bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= 8'h00;
         stall_cnt_q <= 8'h00;
      end else begin
         if (fetch && (fetch_cnt_q != 8'hFF)) begin
            fetch_cnt_q <= fetch_cnt_q + 8'd1;
         end
         if (stall && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_q <= stall_cnt_q + 8'd1;
         end
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch with a behavioural ROM.
module tb_instr_fetch;

   logic clk;
   logic rst_n;
   logic [7:0] rom [16];

   int unsigned vectors;
   int unsigned miscompares;

   instr_fetch_if #(.ADDR_W(4), .INSTR_W(8)) bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [7:0] perf_fetch_cnt;
   logic [7:0] perf_stall_cnt;
`endif

   instr_fetch #(
      .ADDR_W  (4),
      .INSTR_W (8),
      .RESET_PC(4'h0)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt(perf_fetch_cnt),
      .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   assign bus.rom_data = rom[bus.rom_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [7:0] ins,
                          input logic [3:0] pc);
      chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
      chk({tag, ".instr"}, 32'(bus.out_instr), 32'(ins));
      chk({tag, ".pc"},    32'(bus.out_pc),    32'(pc));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rom[0]  = 8'h43;
      rom[1]  = 8'h55;
      rom[2]  = 8'h62;
      for (int i = 3; i < 10; i++) rom[i] = 8'h10 + 8'(i);
      rom[10] = 8'hC0;
      for (int i = 11; i < 16; i++) rom[i] = 8'h20 + 8'(i);

      rst_n              = 1'b0;
      bus.out_ready      = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 4'h0;

      // Reset state
      #1;
      chk_out("reset", 1'b0, 8'h00, 4'h0);
      chk("reset.halted", 32'(bus.halted), 32'd0);
      chk("reset.rom_addr", 32'(bus.rom_addr), 32'd0);
      #11 rst_n = 1'b1;

      // Free run: first valid on first edge after reset release
      step(); chk_out("run0", 1'b1, 8'h43, 4'h0);
      chk("run0.rom_addr", 32'(bus.rom_addr), 32'd1);
      step(); chk_out("run1", 1'b1, 8'h55, 4'h1);
      step(); chk_out("run2", 1'b1, 8'h62, 4'h2);

      // Backpressure for 3 cycles while pc=2 is held
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(); chk_out("bp", 1'b1, 8'h62, 4'h2);
         chk("bp.rom_addr", 32'(bus.rom_addr), 32'd3);
      end
      bus.out_ready = 1'b1;
      step(); chk_out("bp_release", 1'b1, 8'h13, 4'h3);
      step(); chk_out("run4", 1'b1, 8'h14, 4'h4);

      // Redirect to 7 while pc=4 is held under backpressure
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 4'h7;
      step(); chk("redir.valid", 32'(bus.out_valid), 32'd0);
      chk("redir.rom_addr", 32'(bus.rom_addr), 32'd7);
      bus.redirect_valid = 1'b0;
      bus.out_ready      = 1'b1;
      step(); chk_out("redir7", 1'b1, 8'h17, 4'h7);
      step(); chk_out("run8", 1'b1, 8'h18, 4'h8);
      step(); chk_out("run9", 1'b1, 8'h19, 4'h9);

      // Halt instruction delivered with halted on the same edge
      step(); chk_out("halt", 1'b1, 8'hC0, 4'hA);
      chk("halt.halted", 32'(bus.halted), 32'd1);
      step(); chk("halt.drop", 32'(bus.out_valid), 32'd0);
      chk("halt.rom_addr", 32'(bus.rom_addr), 32'd10);
      step(); chk_out("halt.hold", 1'b0, 8'hC0, 4'hA);
      chk("halt.still", 32'(bus.halted), 32'd1);
`ifdef FETCH_PERF_CNT_EN
      chk("perf.fetch", 32'(perf_fetch_cnt), 32'd9);
      chk("perf.stall", 32'(perf_stall_cnt), 32'd4);
`endif

      // Restart from HALT via redirect to 0
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 4'h0;
      step(); chk("restart.halted", 32'(bus.halted), 32'd0);
      chk("restart.valid", 32'(bus.out_valid), 32'd0);
      bus.redirect_valid = 1'b0;
      step(); chk_out("restart", 1'b1, 8'h43, 4'h0);

      // Wrap: no halt words, redirect to E
      rom[10]            = 8'h3A;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 4'hE;
      step(); chk("wrap.valid", 32'(bus.out_valid), 32'd0);
      bus.redirect_valid = 1'b0;
      step(); chk_out("wrapE", 1'b1, 8'h2E, 4'hE);
      step(); chk_out("wrapF", 1'b1, 8'h2F, 4'hF);
      step(); chk_out("wrap0", 1'b1, 8'h43, 4'h0);
      step(); chk_out("wrap1", 1'b1, 8'h55, 4'h1);

      // Async reset between edges
      #2 rst_n = 1'b0;
      #1;
      chk_out("areset", 1'b0, 8'h00, 4'h0);
      chk("areset.halted", 32'(bus.halted), 32'd0);
      chk("areset.rom_addr", 32'(bus.rom_addr), 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("areset.perf_fetch", 32'(perf_fetch_cnt), 32'd0);
      chk("areset.perf_stall", 32'(perf_stall_cnt), 32'd0);
`endif
      #1 rst_n = 1'b1;
      step(); chk_out("resume0", 1'b1, 8'h43, 4'h0);
      step(); chk_out("resume1", 1'b1, 8'h55, 4'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
